// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline hazard and freeze controller for a 5-stage pipeline.
// It resolves load-use stalls, taken-branch squashes and data-memory wait
// freezes, with a bounded wait that force-releases a stuck memory access.
// All state updates on the falling clock edge, matching the pipeline regs.
// Optional build macro: PIPE_CTRL_STATS_EN adds saturating stall/flush
// statistics counters; without it stall_cnt and flush_cnt are tied to zero.
module pipe_ctrl #(
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        idex_MemRead,
  input  logic [4:0]  idex_rt,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        ifid_UsesRt,
  input  logic        branch_taken,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        pc_en,
  output logic        ifid_en,
  output logic        exmem_en,
  output logic        memwb_en,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        memwb_bubble,
  output logic [1:0]  state,
  output logic        mem_timeout,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       lu, frz, timeout_release;

  // Hazard detection and the freeze condition.
  always_comb begin
    lu = idex_MemRead && (idex_rt != 5'd0) &&
         ((idex_rt == ifid_rs) || (ifid_UsesRt && (idex_rt == ifid_rt)));
    timeout_release = (state_q == MEM_WAIT) && (wait_cnt_q >= 8'(MAX_WAIT));
    frz = dmem_req && !dmem_ack && !timeout_release;
  end

  // Next-state and pipeline control outputs, priority: reset, freeze,
  // timeout release, branch squash, load-use stall.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    exmem_en     = 1'b1;
    memwb_en     = 1'b1;
    ifid_flush   = 1'b0;
    idex_bubble  = 1'b0;
    memwb_bubble = 1'b0;
    state_d      = RUN;
    if (!reset_n) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_bubble  = 1'b1;
      memwb_bubble = 1'b1;
    end else if (frz) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
      state_d  = MEM_WAIT;
    end else if (timeout_release) begin
      // Abandon the stuck access: the load result is replaced by a NOP.
      memwb_bubble = 1'b1;
      ifid_flush   = branch_taken;
      idex_bubble  = branch_taken;
    end else if (branch_taken) begin
      // Squashing the dependent instruction makes any load-use stall moot.
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu && (state_q != LU_STALL)) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_bubble = 1'b1;
      state_d     = LU_STALL;
    end
  end

  // Wait counter counts frozen cycles and clears whenever the freeze ends.
  always_comb begin
    wait_cnt_d = (state_d == MEM_WAIT) ? wait_cnt_q + 8'd1 : 8'd0;
  end

  // State register, wait counter and sticky timeout flag.
  always_ff @(negedge clock or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset_n) begin
      state_q     <= RUN;
      wait_cnt_q  <= 8'd0;
      mem_timeout <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      if (timeout_release) mem_timeout <= 1'b1;
    end
  end

  assign state = state_q;

`ifdef PIPE_CTRL_STATS_EN
  logic [15:0] stall_cnt_q, flush_cnt_q;

  // Saturating statistics: stalled PC cycles and IF/ID flushes.
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      if (!pc_en && (stall_cnt_q != 16'hFFFF)) stall_cnt_q <= stall_cnt_q + 16'd1;
      if (ifid_flush && (flush_cnt_q != 16'hFFFF)) flush_cnt_q <= flush_cnt_q + 16'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = 16'd0;
  assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven and hand-sequenced checks of pipe_ctrl with a
// small wait limit (MAX_WAIT=4). Inputs change on the rising edge; outputs
// are sampled shortly after, well away from the falling (active) edge.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clock = 1'b1;
  logic        reset_n = 1'b0;
  logic        idex_MemRead, ifid_UsesRt, branch_taken, dmem_req, dmem_ack;
  logic [4:0]  idex_rt, ifid_rs, ifid_rt;
  logic        pc_en, ifid_en, exmem_en, memwb_en;
  logic        ifid_flush, idex_bubble, memwb_bubble, mem_timeout;
  logic [1:0]  state;
  logic [15:0] stall_cnt, flush_cnt;

  pipe_ctrl #(.MAX_WAIT(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .idex_MemRead(idex_MemRead), .idex_rt(idex_rt),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt), .ifid_UsesRt(ifid_UsesRt),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ack(dmem_ack),
    .pc_en(pc_en), .ifid_en(ifid_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_bubble(idex_bubble), .memwb_bubble(memwb_bubble),
    .state(state), .mem_timeout(mem_timeout),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    string      name;
    logic       mr;
    logic [4:0] xrt, rs, rt;
    logic       ur, br, req, ack;
    logic [3:0] en;   // {pc, ifid, exmem, memwb}
    logic       fl, ib, mb;
    logic [1:0] st;
    logic       to;
  } vec_t;

  typedef struct {
    string      name;
    logic [9:0] outs;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t v(input string n, input logic mr, input logic [4:0] xrt,
                             input logic [4:0] rs, input logic [4:0] rt, input logic ur,
                             input logic br, input logic req, input logic ack,
                             input logic [3:0] en, input logic fl, input logic ib,
                             input logic mb, input logic [1:0] st, input logic to);
    vec_t r;
    r.name = n; r.mr = mr; r.xrt = xrt; r.rs = rs; r.rt = rt; r.ur = ur;
    r.br = br; r.req = req; r.ack = ack; r.en = en; r.fl = fl; r.ib = ib;
    r.mb = mb; r.st = st; r.to = to;
    return r;
  endfunction

  // Drive one cycle of stimulus, queue its expectation, compare, move on.
  task automatic step(input vec_t t);
    exp_t e, got;
    idex_MemRead = t.mr; idex_rt = t.xrt; ifid_rs = t.rs; ifid_rt = t.rt;
    ifid_UsesRt = t.ur; branch_taken = t.br; dmem_req = t.req; dmem_ack = t.ack;
    e.name = t.name;
    e.outs = {t.en, t.fl, t.ib, t.mb, t.st, t.to};
    sb_q.push_back(e);
    #2;
    got = sb_q.pop_front();
    check(got.name,
          {22'd0, pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_bubble,
           memwb_bubble, state, mem_timeout},
          {22'd0, got.outs});
    @(posedge clock);
  endtask

  task automatic idle_inputs();
    idex_MemRead = 1'b0; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
    ifid_UsesRt = 1'b0; branch_taken = 1'b0; dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  // Assert reset asynchronously mid-cycle, check reset outputs, release on a rising edge.
  task automatic reset_dut(input string tag);
    #2;
    reset_n = 1'b0;
    idle_inputs();
    #1;
    check({tag, "_rst_outs"},
          {22'd0, pc_en, ifid_en, exmem_en, memwb_en, ifid_flush, idex_bubble,
           memwb_bubble, state, mem_timeout},
          {22'd0, 4'b0000, 3'b111, 2'd0, 1'b0});
    check({tag, "_rst_cnts"}, {stall_cnt, flush_cnt}, 32'd0);
    repeat (2) @(posedge clock);
    reset_n = 1'b1;
  endtask

  task automatic check_counts(input string tag, input int stalls, input int flushes);
    check({tag, "_stall_cnt"}, {16'd0, stall_cnt}, 32'(STATS * stalls));
    check({tag, "_flush_cnt"}, {16'd0, flush_cnt}, 32'(STATS * flushes));
  endtask

  vec_t tbl[15];

  initial begin
    idle_inputs();
    //            name              mr xrt rs rt ur br rq ak en     fl ib mb st to
    tbl[0]  = v("idle",            0, 0,  0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0);
    tbl[1]  = v("lu_rs",           1, 5,  5, 0, 0, 0, 0, 0, 4'h3, 0, 1, 0, 0, 0);
    tbl[2]  = v("lu_hold",         1, 5,  5, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 1, 0);
    tbl[3]  = v("idle_after_lu",   0, 0,  0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0);
    tbl[4]  = v("lu_r0",           1, 0,  0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0);
    tbl[5]  = v("lu_rt",           1, 7,  3, 7, 1, 0, 0, 0, 4'h3, 0, 1, 0, 0, 0);
    tbl[6]  = v("idle_in_stall",   0, 0,  0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 1, 0);
    tbl[7]  = v("rt_not_used",     1, 7,  3, 7, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0);
    tbl[8]  = v("no_load",         0, 5,  5, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0);
    tbl[9]  = v("lu_and_branch",   1, 9,  9, 0, 0, 1, 0, 0, 4'hF, 1, 1, 0, 0, 0);
    tbl[10] = v("idle_after_br",   0, 0,  0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0);
    tbl[11] = v("branch",          0, 0,  0, 0, 0, 1, 0, 0, 4'hF, 1, 1, 0, 0, 0);
    tbl[12] = v("lu_rt_again",     1, 2,  4, 2, 1, 0, 0, 0, 4'h3, 0, 1, 0, 0, 0);
    tbl[13] = v("branch_in_stall", 1, 2,  2, 0, 0, 1, 0, 0, 4'hF, 1, 1, 0, 1, 0);
    tbl[14] = v("idle_end",        0, 0,  0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0);

    reset_dut("init");
    for (int i = 0; i < 15; i++) step(tbl[i]);
    check_counts("table", 3, 3);

    // Single load-use stall straight out of reset.
    reset_dut("lu");
    step(v("lu_r5",        1, 5, 5, 0, 0, 0, 0, 0, 4'h3, 0, 1, 0, 0, 0));
    step(v("lu_r5_stall",  0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 1, 0));
    step(v("lu_r5_run",    0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0));
    check_counts("lu", 1, 0);

    // Load-use and taken branch together: branch wins.
    reset_dut("lubr");
    step(v("lubr",         1, 5, 5, 0, 0, 1, 0, 0, 4'hF, 1, 1, 0, 0, 0));
    step(v("lubr_next",    0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0));
    check_counts("lubr", 0, 1);

    // Memory wait with ack after three frozen cycles.
    reset_dut("ack");
    step(v("frz1",         0, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 0, 0));
    step(v("frz2",         0, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 2, 0));
    step(v("frz3",         0, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 2, 0));
    step(v("ack",          0, 0, 0, 0, 0, 0, 1, 1, 4'hF, 0, 0, 0, 2, 0));
    step(v("after_ack",    0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0));
    check_counts("ack", 3, 0);
    // Ack coinciding with a load-use hazard goes to LU_STALL.
    step(v("frz_lu",       0, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 0, 0));
    step(v("ack_lu",       1, 6, 6, 0, 0, 0, 1, 1, 4'h3, 0, 1, 0, 2, 0));
    step(v("ack_lu_stall", 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 1, 0));
    // Freeze outranks a taken branch; the branch applies on the ack cycle.
    step(v("frz_br",       0, 0, 0, 0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 0, 0));
    step(v("ack_br",       0, 0, 0, 0, 0, 1, 1, 1, 4'hF, 1, 1, 0, 2, 0));
    step(v("after_ack_br", 0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0));
    check_counts("ack2", 6, 1);

    // No ack: forced release after MAX_WAIT=4 frozen cycles.
    reset_dut("tmo");
    step(v("tmo_frz1",     0, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 0, 0));
    step(v("tmo_frz2",     0, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 2, 0));
    step(v("tmo_frz3",     0, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 2, 0));
    step(v("tmo_frz4",     0, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 2, 0));
    step(v("tmo_release",  0, 0, 0, 0, 0, 0, 1, 0, 4'hF, 0, 0, 1, 2, 0));
    step(v("tmo_sticky1",  0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 1));
    step(v("tmo_sticky2",  0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 1));
    check_counts("tmo", 4, 0);
    // Enter MEM_WAIT again, then reset while frozen.
    step(v("tmo_refrz1",   0, 0, 0, 0, 0, 1, 1, 0, 4'h0, 0, 0, 0, 0, 1));
    step(v("tmo_refrz2",   0, 0, 0, 0, 0, 0, 1, 0, 4'h0, 0, 0, 0, 2, 1));
    reset_dut("midwait");
    step(v("post_reset",   0, 0, 0, 0, 0, 0, 0, 0, 4'hF, 0, 0, 0, 0, 0));
    check_counts("post_reset", 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Hard bound on simulated time so the bench always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MAX_WAIT, default 15, max consecutive dmem wait cycles before forced release (range 1..255).
REQ-002 SHALL have port clock  input  1  pipeline clock; all state updates on negedge, matching the pipeline registers.
REQ-003 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port idex_MemRead  input  1  load instruction in ID/EX.
REQ-005 SHALL have port idex_rt  input  5  load destination register in ID/EX.
REQ-006 SHALL have ports ifid_rs, ifid_rt  input  5 each  source registers of the instruction in IF/ID.
REQ-007 SHALL have port ifid_UsesRt  input  1  IF/ID instruction reads rt.
REQ-008 SHALL have port branch_taken  input  1  branch resolved taken in EX.
REQ-009 SHALL have ports dmem_req, dmem_ack  input  1 each  MEM-stage access pending / data memory done.
REQ-010 SHALL have outputs pc_en, ifid_en, exmem_en, memwb_en  output  1 each  register load enables.
REQ-011 SHALL have outputs ifid_flush, idex_bubble, memwb_bubble  output  1 each  insert NOP (control bits zeroed).
REQ-012 SHALL have outputs state  output  2  (RUN=0, LU_STALL=1, MEM_WAIT=2) and mem_timeout  output  1  sticky error.
REQ-013 SHALL have outputs stall_cnt, flush_cnt  output  16 each  statistics.

Function
REQ-014 Hazard: lu = idex_MemRead & idex_rt!=0 & (idex_rt==ifid_rs | (ifid_UsesRt & idex_rt==ifid_rt)).
REQ-015 Freeze: frz = dmem_req & ~dmem_ack & ~timeout_release; highest priority.
REQ-016 frz=1: all enables 0, all flush/bubble 0 (entire pipe holds); state -> MEM_WAIT.
REQ-017 Else branch_taken=1: all enables 1, ifid_flush=1, idex_bubble=1; lu ignored (dependent instr squashed); state -> RUN.
REQ-018 Else lu=1 in RUN: pc_en=0, ifid_en=0, idex_bubble=1, exmem_en=memwb_en=1; state -> LU_STALL.
REQ-019 LU_STALL: lu not re-evaluated; normal flow (all enables 1, no bubbles) unless frz/branch; state -> RUN next edge.
REQ-020 Otherwise: all enables 1, flush/bubble 0; outputs are combinational from state and inputs, no added latency.
REQ-021 MEM_WAIT: 8-bit wait counter increments per frozen cycle; cleared on leaving MEM_WAIT.
REQ-022 Counter reaching MAX_WAIT: timeout_release=1 that cycle, mem_timeout set (sticky until reset), memwb_bubble=1, pipe advances, state -> RUN.
REQ-023 dmem_ack=1 in MEM_WAIT: normal flow that cycle, state -> RUN (or LU_STALL if lu and no branch).
REQ-024 memwb_bubble SHALL be 1 only on timeout release.

Reset
REQ-025 reset_n=0 SHALL immediately force state=RUN, wait counter=0, mem_timeout=0, stall_cnt=flush_cnt=0.
REQ-026 During reset: all enables 0, ifid_flush=idex_bubble=memwb_bubble=1; reset mid-MEM_WAIT abandons the wait.
REQ-027 First negedge after reset_n rises SHALL evaluate normally from RUN.

Configuration
REQ-028 Macro PIPE_CTRL_STATS_EN defined: stall_cnt +1 per negedge with pc_en=0, flush_cnt +1 per negedge with ifid_flush=1 (not in reset); both saturate at 0xFFFF.
REQ-029 Macro undefined: counters not built; stall_cnt, flush_cnt ports present, tied 0.

Verification
REQ-030 Load r5 in ID/EX, IF/ID rs=5 -> one cycle pc_en=0, idex_bubble=1, state=1, then RUN; stall_cnt=1.
REQ-031 Load r0 in ID/EX, IF/ID rs=0 -> no stall, state stays 0.
REQ-032 lu and branch_taken same cycle -> ifid_flush=1, idex_bubble=1, pc_en=1, state=0; flush_cnt=1.
REQ-033 dmem_req=1, ack after 3 cycles -> 3 cycles all enables 0, state=2, release on ack, mem_timeout=0.
REQ-034 dmem_req=1, never ack, MAX_WAIT=4 -> release after 4 frozen cycles, memwb_bubble=1 once, mem_timeout=1 until reset.
REQ-035 reset_n low mid-MEM_WAIT -> state=0, counters 0, bubbles 1 asynchronously.
